// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: reads a tile-map entry, then the low/high bitplane
// bytes for one pixel row, and hands them to the pixel pipe via valid/ready.
module bg_tile_fetcher #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1,
    parameter int MAP_COLS = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              map_sel,
    input  logic              signed_mode,
    input  logic [4:0]        tile_x,
    input  logic [4:0]        tile_y,
    input  logic [2:0]        fine_y,
    input  logic              x_flip,
    input  logic              y_flip,
    output logic              vram_rd_en,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [DATA_W-1:0] vram_rd_data,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        plane_lo,
    output logic [7:0]        plane_hi,
    output logic [DATA_W-1:0] tile_idx
);

    typedef enum logic [2:0] {
        IDLE, MAP_RD, MAP_WAIT, LO_RD, LO_WAIT, HI_RD, HI_WAIT, DONE
    } state_t;

    typedef struct packed {
        logic       map_sel;
        logic       signed_mode;
        logic [4:0] tx;
        logic [4:0] ty;
        logic [2:0] fy;
        logic       xf;
        logic       yf;
    } req_t;

    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        lo_q, lo_d, hi_q, hi_d;
    logic [DATA_W-1:0] idx_q, idx_d;

    logic [ADDR_W-1:0] map_base, map_addr;
    logic [ADDR_W-1:0] idx_sext, idx_zext, idx_ext, tile_base, tile_addr;
    logic [2:0]        row;
    logic [7:0]        rd8, rd_flip;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign map_base = req_q.map_sel ? ADDR_W'(32'h1C00) : ADDR_W'(32'h1800);
    assign map_addr = map_base + ADDR_W'(req_q.ty) * ADDR_W'(MAP_COLS) + ADDR_W'(req_q.tx);

    // Address arithmetic is done modulo 2^ADDR_W, which matches computing
    // wider and truncating, so signed indices wrap naturally.
    assign row       = req_q.yf ? (3'd7 - req_q.fy) : req_q.fy;
    assign idx_sext  = ADDR_W'($signed(idx_q));
    assign idx_zext  = ADDR_W'(idx_q);
    assign idx_ext   = req_q.signed_mode ? idx_sext : idx_zext;
    assign tile_base = req_q.signed_mode ? ADDR_W'(32'h1000) : '0;
    assign tile_addr = tile_base + (idx_ext << 4) + ADDR_W'({row, 1'b0});

    assign rd8     = 8'(vram_rd_data);
    assign rd_flip = req_q.xf ? rev8(rd8) : rd8;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        idx_d      = idx_q;
        vram_rd_en = 1'b0;
        vram_addr  = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    req_d.map_sel     = map_sel;
                    req_d.signed_mode = signed_mode;
                    req_d.tx          = tile_x;
                    req_d.ty          = tile_y;
                    req_d.fy          = fine_y;
                    req_d.xf          = x_flip;
                    req_d.yf          = y_flip;
                    state_d           = MAP_RD;
                end
            end
            MAP_RD: begin
                vram_rd_en = 1'b1;
                vram_addr  = map_addr;
                cnt_d      = LAT_M1;
                state_d    = MAP_WAIT;
            end
            MAP_WAIT: begin
                if (cnt_q == 3'd0) begin
                    idx_d   = vram_rd_data;
                    state_d = LO_RD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            LO_RD: begin
                vram_rd_en = 1'b1;
                vram_addr  = tile_addr;
                cnt_d      = LAT_M1;
                state_d    = LO_WAIT;
            end
            LO_WAIT: begin
                if (cnt_q == 3'd0) begin
                    lo_d    = rd_flip;
                    state_d = HI_RD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HI_RD: begin
                vram_rd_en = 1'b1;
                vram_addr  = tile_addr + ADDR_W'(1);
                cnt_d      = LAT_M1;
                state_d    = HI_WAIT;
            end
            HI_WAIT: begin
                if (cnt_q == 3'd0) begin
                    hi_d    = rd_flip;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign plane_lo  = lo_q;
    assign plane_hi  = hi_q;
    assign tile_idx  = idx_q;

endmodule

// File: doc/bg_tile_fetcher.md
Name: bg_tile_fetcher

Overview:
- Background tile fetch engine for the GBC PPU.
- Per request it reads the tile-map entry from VRAM and computes the tile-data address. Addressing is either unsigned (0x8000 base) or signed (0x8800/0x9000 base).
- It then fetches the low and high bitplane bytes for one pixel row and presents them with a valid/ready handshake.
- It sits between the PPU line scheduler and VRAM read port A, and generalises the signed-index address calculation to parametrised widths, read latency and flip modes.

Parameters:
- ADDR_W, 13, VRAM byte address width (VRAM-relative, 0x0000 = CPU 0x8000)
- DATA_W, 8, VRAM data width and tile index width
- READ_LAT, 1, cycles from vram_rd_en to vram_rd_data valid (legal 1..4)
- MAP_COLS, 32, tile-map row stride in entries

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; accepted only when busy=0
- map_sel  in  1  0: map at 0x1800, 1: map at 0x1C00
- signed_mode  in  1  1: base 0x1000 with sign-extended index; 0: base 0x0000 with unsigned index
- tile_x  in  5  map column
- tile_y  in  5  map row
- fine_y  in  3  pixel row within tile
- x_flip  in  1  reverse bit order of both output planes
- y_flip  in  1  use row 7-fine_y
- vram_rd_en  out  1  one-cycle read strobe
- vram_addr  out  ADDR_W  read address, valid while vram_rd_en=1
- vram_rd_data  in  DATA_W  read data, sampled READ_LAT cycles after vram_rd_en
- busy  out  1  high from accept until output handshake completes
- out_valid  out  1  plane data valid
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- plane_lo  out  8  low bitplane byte, bit 7 = leftmost pixel
- plane_hi  out  8  high bitplane byte
- tile_idx  out  DATA_W  raw map entry, for debug and attribute lookup

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; latched request fields cleared.
- IDLE: when start=1, latch map_sel, signed_mode, tile_x, tile_y, fine_y, x_flip and y_flip; set busy=1; go to MAP_RD. When busy=1, start is ignored and has no queueing.
- Map address = (map_sel ? 0x1C00 : 0x1800) + tile_y*MAP_COLS + tile_x.
- Row r = y_flip ? 7-fine_y : fine_y.
- Tile address, unsigned mode: idx*16 + r*2.
- Tile address, signed mode: 0x1000 + sext(idx)*16 + r*2, computed at ADDR_W+4 bits and truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - idx=0x96 gives 0x0960 + r*2.
  - idx=0x7F gives 0x17F0.
  - idx=0x80 gives 0x0800.
- States and outputs:
  - MAP_RD: vram_rd_en=1 and vram_addr=map address for one cycle.
  - MAP_WAIT: count READ_LAT cycles, then capture tile_idx.
  - LO_RD: vram_rd_en=1 and vram_addr=tile address.
  - LO_WAIT: capture plane_lo.
  - HI_RD: vram_rd_en=1 and vram_addr=tile address+1.
  - HI_WAIT: capture plane_hi.
  - DONE: out_valid=1.
- The wait counter is a 3-bit down-counter loaded with READ_LAT-1 on each RD state. Data is captured on the cycle the counter reads 0.
- x_flip: bit order of each captured plane byte is reversed before it is registered.
- Latency: start accepted at edge T.
  - Read strobes occur in cycles T+1, T+2+L and T+3+2L.
  - out_valid rises at T+4+3L, which is T+7 for L=1.
- DONE: out_valid, plane_lo, plane_hi and tile_idx stay stable until out_valid&&out_ready. On that edge, out_valid=0 and busy=0, and the state returns to IDLE.
  - start in the handshake cycle is ignored; it is accepted from the next cycle.
  - Plane data and tile_idx hold their last values after the handshake.
- vram_rd_en is never asserted outside the RD states; there is at most one outstanding read.
- Reset mid-operation: immediate return to IDLE with outputs cleared. No read strobe is issued after reset is released until a new start.
- start held high continuously: one request per IDLE visit.

Test Plan:
- Signed mode, map_sel=0, tile (3,2), fine_y=5, map[0x1843]=0x96, VRAM[0x096A]=0xA5, VRAM[0x096B]=0x3C, out_ready=1 -> strobes at 0x1843, 0x096A, 0x096B; plane_lo=0xA5, plane_hi=0x3C, tile_idx=0x96; out_valid at T+7.
- Unsigned mode, idx=0x96, fine_y=0, x_flip=1, data 0x01/0x80 -> addresses 0x0960/0x0961; plane_lo=0x80, plane_hi=0x01.
- Signed boundaries: idx 0x7F and 0x80 with y_flip=1, fine_y=0 -> lo addresses 0x17FE and 0x080E.
- READ_LAT=3: response strobes spaced 4 cycles apart; out_valid at T+13; start pulses while busy are ignored and the read count stays 3.
- Back-pressure: out_ready=0 for 10 cycles -> outputs stable and busy=1; out_ready=1 -> one-cycle handshake, busy falls; map_sel=1, tile (31,31) -> map address 0x1FFF.
- reset_n low during LO_WAIT -> all outputs 0 immediately; no vram_rd_en until the next start; next request completes normally.
